disp_share_arb: RTL and testbench

Time-shares the 8-digit seven-segment display between up to `N_REQ` requesters, such as the PC, ALU result, register probe and memory probe. It picks one owner by round-robin and holds it for a minimum dwell time. It supports manual advance and freeze, and produces the registered 32-bit word driven into the display multiplexer's `t` input. Digit 3 (bits [15:12]) is overwritten with the owner index, so the user can see which source is on screen.

---
 rtl/disp_share_arb.sv | 136 +++++++++++++
 tb/tb_disp_share_arb.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/disp_share_arb.sv
// Round-robin owner of the seven-segment display with a minimum dwell, manual advance and freeze.
// The registered word shows the owner's data with digit 3 replaced by the owner index.
module disp_share_arb #(
  parameter int N_REQ        = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int IDX_W        = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [32*N_REQ-1:0]    data,
  input  logic                   next_btn,
  input  logic                   freeze,
  output logic [31:0]            disp_word,
  output logic                   disp_valid,
  output logic [N_REQ-1:0]       grant,
  output logic [IDX_W-1:0]       owner
);
  localparam int CNT_W = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, FROZEN} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d, ptr_q, ptr_d, pick_idx;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               valid_q, valid_d, pick_en;
  logic [31:0]        word_q, word_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  int                 pick_from;

  // First requester scanning upward from start, wrapping; lowest offset wins.
  function automatic logic [IDX_W-1:0] pick(input logic [N_REQ-1:0] r, input int start);
    logic [IDX_W-1:0] res;
    int j;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (start + k) % N_REQ;
      if (r[j]) res = IDX_W'(j);
    end
    return res;
  endfunction

  function automatic logic [31:0] compose(input logic [32*N_REQ-1:0] d, input logic [IDX_W-1:0] idx);
    logic [31:0] w;
    w        = d[32*idx +: 32];
    w[15:12] = 4'(idx);
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  // With the owner's request gone, an empty req means nothing is left to show.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req != '0) state_d = SHOW;
      SHOW:    if (freeze) state_d = FROZEN;
               else if (req == '0) state_d = IDLE;
      FROZEN:  if (!freeze) state_d = (req == '0) ? IDLE : SHOW;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    word_d    = word_q;
    cnt_d     = cnt_q;
    pick_en   = 1'b0;
    pick_from = 0;
    pick_idx  = '0;
    unique case (state_q)
      IDLE: if (req != '0) begin
        pick_en   = 1'b1;
        pick_from = int'(ptr_q);
      end
      SHOW, FROZEN: if (!freeze) begin
        // The unfreeze edge behaves like a SHOW edge, except next_btn is ignored.
        if (!req[owner_q]) begin
          if (req != '0) begin
            pick_en   = 1'b1;
            pick_from = (int'(owner_q) + 1) % N_REQ;
          end else begin
            owner_d = '0;
            grant_d = '0;
            valid_d = 1'b0;
            word_d  = '0;
            cnt_d   = '0;
          end
        end else if (cnt_q == '0 || (state_q == SHOW && next_btn)) begin
          pick_en   = 1'b1;
          pick_from = (int'(owner_q) + 1) % N_REQ;
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          word_d = compose(data, owner_q);
        end
      end
      default: ;
    endcase
    if (pick_en) begin
      pick_idx = pick(req, pick_from);
      owner_d  = pick_idx;
      ptr_d    = pick_idx;
      grant_d  = N_REQ'(1) << pick_idx;
      valid_d  = 1'b1;
      cnt_d    = RELOAD;
      word_d   = compose(data, pick_idx);
    end
  end

  assign disp_word  = word_q;
  assign disp_valid = valid_q;
  assign grant      = grant_q;
  assign owner      = owner_q;
endmodule

// File: tb/tb_disp_share_arb.sv
// Directed bench for disp_share_arb with N_REQ=4, DWELL_CYCLES=4.
module tb_disp_share_arb;
  logic         clk = 1'b0;
  logic         reset, next_btn, freeze;
  logic [3:0]   req;
  logic [127:0] data;
  logic [31:0]  disp_word;
  logic         disp_valid;
  logic [3:0]   grant;
  logic [1:0]   owner;

  int checks   = 0;
  int failures = 0;

  disp_share_arb #(.N_REQ(4), .DWELL_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .req(req), .data(data),
    .next_btn(next_btn), .freeze(freeze),
    .disp_word(disp_word), .disp_valid(disp_valid),
    .grant(grant), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] tagw(input logic [31:0] d, input int i);
    return {d[31:16], 4'(i), d[11:0]};
  endfunction

  int rot[4] = '{0, 1, 3, 0};
  int o;

  initial begin
    reset = 1'b1; req = '0; next_btn = 1'b0; freeze = 1'b0;
    data[31:0]   = 32'h0A0B_0C0D;
    data[63:32]  = 32'h1111_2222;
    data[95:64]  = 32'h1234_5678;
    data[127:96] = 32'h9876_5432;
    repeat (3) step();
    chk("rst_word", disp_word, 32'h0);
    chk("rst_valid", 32'(disp_valid), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);

    reset = 1'b0; req = 4'b0100;
    step();
    chk("idle_grant", 32'(grant), 32'h4);
    chk("idle_owner", 32'(owner), 32'h2);
    chk("idle_valid", 32'(disp_valid), 32'h1);
    chk("idle_word", disp_word, 32'h1234_2678);

    // Rotation over 1011 from a fresh reset
    reset = 1'b1; req = '0;
    step();
    reset = 1'b0; req = 4'b1011;
    for (int k = 0; k < 16; k++) begin
      step();
      o = rot[k/4];
      chk("rot_owner", 32'(owner), 32'(o));
      chk("rot_grant", 32'(grant), 32'(4'b0001 << o));
      chk("rot_word", disp_word, tagw(data[32*o +: 32], o));
    end

    step();
    chk("rot_to1", 32'(owner), 32'h1);
    next_btn = 1'b1;
    step();
    next_btn = 1'b0;
    chk("next_owner", 32'(owner), 32'h3);
    chk("next_word", disp_word, 32'h9876_3432);
    step();
    chk("next_hold", 32'(owner), 32'h3);
    req = 4'b0011;
    step();
    chk("drop_owner", 32'(owner), 32'h0);
    repeat (3) begin
      step();
      chk("drop_reload", 32'(owner), 32'h0);
    end
    step();
    chk("drop_rot", 32'(owner), 32'h1);
    req = '0;
    step();
    chk("toidle_valid", 32'(disp_valid), 32'h0);
    chk("toidle_grant", 32'(grant), 32'h0);
    chk("toidle_word", disp_word, 32'h0);

    // Freeze with changing data and an ignored next_btn
    data[31:0] = 32'hAAAA_AAAA; req = 4'b0001;
    step();
    chk("frz_start", 32'(owner), 32'h0);
    chk("frz_word0", disp_word, 32'hAAAA_0AAA);
    step();
    freeze = 1'b1; data[31:0] = 32'h5555_5555; req = 4'b0011;
    step();
    chk("frz_word1", disp_word, 32'hAAAA_0AAA);
    next_btn = 1'b1;
    step();
    next_btn = 1'b0;
    chk("frz_owner", 32'(owner), 32'h0);
    chk("frz_grant", 32'(grant), 32'h1);
    chk("frz_word2", disp_word, 32'hAAAA_0AAA);
    step();
    chk("frz_word3", disp_word, 32'hAAAA_0AAA);
    freeze = 1'b0;
    step();
    chk("unfrz_word", disp_word, 32'h5555_0555);
    chk("unfrz_owner", 32'(owner), 32'h0);
    step();
    chk("unfrz_dwell", 32'(owner), 32'h0);
    step();
    chk("unfrz_rot", 32'(owner), 32'h1);
    chk("unfrz_rotw", disp_word, 32'h1111_1222);

    // freeze and next_btn together
    freeze = 1'b1; next_btn = 1'b1;
    step();
    freeze = 1'b0; next_btn = 1'b0;
    chk("sim_owner", 32'(owner), 32'h1);
    chk("sim_grant", 32'(grant), 32'h2);
    chk("sim_word", disp_word, 32'h1111_1222);
    req = 4'b1000;
    step();
    chk("unfrz_drop", 32'(owner), 32'h3);
    step();
    chk("mid_owner", 32'(owner), 32'h3);
    reset = 1'b1;
    step();
    chk("mrst_owner", 32'(owner), 32'h0);
    chk("mrst_grant", 32'(grant), 32'h0);
    chk("mrst_valid", 32'(disp_valid), 32'h0);
    chk("mrst_word", disp_word, 32'h0);
    reset = 1'b0; req = 4'b1111;
    step();
    chk("post_owner", 32'(owner), 32'h0);
    chk("post_grant", 32'(grant), 32'h1);
    chk("post_word", disp_word, 32'h5555_0555);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
